// File: rtl/jtdsp16_cache.sv
// jtdsp16_cache
//   Instruction cache and hardware loop controller for the DSP16 core.
//   A "do K { N instructions }" captures N words from the program ROM while
//   they execute (FILL), then replays them from internal registers K-1 more
//   times while the program counter is held (REPLAY). A later "redo K"
//   replays the cached block K times.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   cen         clock enable, one instruction word consumed per cen cycle
//   rom_dout    instruction word from program ROM
//   do_start    start a do loop (sampled on cen, IDLE only)
//   redo_start  replay the last cached block (sampled on cen, IDLE only)
//   ni          number of words in the block (clamped to DEPTH)
//   k           iteration count
//   cache_dout  instruction word from the cache (0 outside REPLAY)
//   use_cache   decoder takes cache_dout instead of rom_dout
//   pc_halt     hold the program counter
//   busy        loop active (FILL or REPLAY), masks interrupts
//   valid       cache holds a complete block
//   iter_left   iterations remaining, including the current one
//   loop_end    pulse while the final word of the final iteration is consumed
//
// state  | meaning
// IDLE   | no loop active, requests accepted
// FILL   | first iteration executes from ROM, words captured into the cache
// REPLAY | remaining iterations execute from the cache, PC held

module jtdsp16_cache #(
  parameter int DW    = 16,
  parameter int DEPTH = 15,
  parameter int CW    = 7,
  parameter int AW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [DW-1:0] rom_dout,
  input  logic          do_start,
  input  logic          redo_start,
  input  logic [AW-1:0] ni,
  input  logic [CW-1:0] k,
  output logic [DW-1:0] cache_dout,
  output logic          use_cache,
  output logic          pc_halt,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] iter_left,
  output logic          loop_end
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, nlat;
  logic [AW-1:0] nlat_in, nlat_m1;
  logic          do_go, redo_go, last_word, final_iter;

  // Widened compare keeps the clamp meaningful for any DEPTH/AW pairing.
  assign nlat_in    = (32'(ni) > DEPTH) ? AW'(DEPTH) : ni;
  assign nlat_m1    = nlat - AW'(1);
  assign final_iter = (iter_left == CW'(1));

  always_ff @(posedge clk) begin
    if (rst)      state <= S_IDLE;
    else if (cen) state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cache_dout = '0;
    use_cache  = 1'b0;
    pc_halt    = 1'b0;
    busy       = 1'b0;
    do_go      = 1'b0;
    redo_go    = 1'b0;
    last_word  = 1'b0;
    case (state)
      S_IDLE: begin
        do_go   = do_start && (ni != '0) && (k != '0);
        // do_start has priority even when the do request itself is rejected
        redo_go = !do_start && redo_start && valid && (k != '0);
        if (do_go)        state_nx = S_FILL;
        else if (redo_go) state_nx = S_REPLAY;
      end
      S_FILL: begin
        busy      = 1'b1;
        last_word = (wptr == nlat_m1);
        if (last_word) state_nx = final_iter ? S_IDLE : S_REPLAY;
      end
      S_REPLAY: begin
        busy       = 1'b1;
        use_cache  = 1'b1;
        pc_halt    = 1'b1;
        cache_dout = mem[rptr];
        last_word  = (rptr == nlat_m1);
        if (last_word && final_iter) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    loop_end = cen && !rst && last_word && final_iter;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      nlat      <= '0;
      iter_left <= '0;
      valid     <= 1'b0;
    end else if (cen) begin
      case (state)
        S_IDLE: begin
          if (do_go) begin
            nlat      <= nlat_in;
            iter_left <= k;
            wptr      <= '0;
            valid     <= 1'b0;
          end else if (redo_go) begin
            iter_left <= k;
            rptr      <= '0;
          end
        end
        S_FILL: begin
          if (last_word) begin
            valid     <= 1'b1;
            rptr      <= '0;
            // reaches 0 when this was the only iteration
            iter_left <= iter_left - CW'(1);
          end else begin
            wptr <= wptr + AW'(1);
          end
        end
        S_REPLAY: begin
          if (last_word) begin
            iter_left <= iter_left - CW'(1);
            rptr      <= '0;
          end else begin
            rptr <= rptr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Cache storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && cen && state == S_FILL) mem[wptr] <= rom_dout;
  end

endmodule

// File: tb/tb_jtdsp16_cache.sv
module tb_jtdsp16_cache;
  localparam int DW = 16;
  localparam int DEPTH = 15;
  localparam int CW = 7;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic [DW-1:0] rom_dout = '0;
  logic          do_start = 1'b0;
  logic          redo_start = 1'b0;
  logic [AW-1:0] ni = '0;
  logic [CW-1:0] k = '0;
  logic [DW-1:0] cache_dout;
  logic          use_cache, pc_halt, busy, valid, loop_end;
  logic [CW-1:0] iter_left;

  jtdsp16_cache #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .rom_dout(rom_dout),
    .do_start(do_start), .redo_start(redo_start), .ni(ni), .k(k),
    .cache_dout(cache_dout), .use_cache(use_cache), .pc_halt(pc_halt),
    .busy(busy), .valid(valid), .iter_left(iter_left), .loop_end(loop_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          uc;
    logic          ph;
    logic          bsy;
    logic          vld;
    logic [CW-1:0] it;
    logic          le;
  } exp_t;

  // One planned consumed word of an active loop.
  typedef struct {
    bit fill;
    int idx;
    int iter;
    bit last;
  } ent_t;

  exp_t       expq[$];
  ent_t       plan[$];
  logic [DW-1:0] mmem [DEPTH];
  bit         mvalid = 1'b0;
  int         mn = 0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_plan(input bit isdo, input int kk);
    for (int it = 0; it < kk; it++)
      for (int i = 0; i < mn; i++)
        plan.push_back('{fill: (isdo && it == 0), idx: i, iter: kk - it,
                         last: (it == kk-1 && i == mn-1)});
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit r, input bit c, input bit d, input bit rd,
                      input int n_in, input int k_in);
    exp_t e;
    ent_t p;
    logic [DW-1:0] rom;
    rom = 16'($urandom());
    rst = r; cen = c; do_start = d; redo_start = rd;
    ni = AW'(n_in); k = CW'(k_in); rom_dout = rom;
    e = '0;
    e.vld = mvalid;
    if (plan.size() > 0) begin
      p = plan[0];
      e.bsy = 1'b1;
      e.it  = CW'(p.iter);
      if (!p.fill) begin
        e.uc = 1'b1; e.ph = 1'b1; e.dout = mmem[p.idx];
      end
      e.le = c && !r && p.last;
    end
    expq.push_back(e);
    if (r) begin
      plan.delete();
      mvalid = 1'b0;
    end else if (c) begin
      if (plan.size() > 0) begin
        p = plan.pop_front();
        if (p.fill) begin
          mmem[p.idx] = rom;
          if (p.idx == mn-1) mvalid = 1'b1;
        end
      end else if (d && n_in != 0 && k_in != 0) begin
        mn = (n_in > DEPTH) ? DEPTH : n_in;
        mvalid = 1'b0;
        build_plan(1'b1, k_in);
      end else if (rd && !d && mvalid && k_in != 0) begin
        build_plan(1'b0, k_in);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_idle(input int bound);
    int g = 0;
    while (plan.size() > 0 && g < bound) begin
      step(0, 1, 0, 0, 0, 0);
      g++;
    end
    checks++;
    if (plan.size() > 0) begin
      failures++;
      $display("FAIL loop_drain: %0d words left after %0d cycles", plan.size(), bound);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("cache_dout", 32'(cache_dout), 32'(e.dout));
        chk("use_cache",  32'(use_cache),  32'(e.uc));
        chk("pc_halt",    32'(pc_halt),    32'(e.ph));
        chk("busy",       32'(busy),       32'(e.bsy));
        chk("valid",      32'(valid),      32'(e.vld));
        chk("iter_left",  32'(iter_left),  32'(e.it));
        chk("loop_end",   32'(loop_end),   32'(e.le));
      end
    end
  end

  initial begin : driver
    @(posedge clk); #1;
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // do ni=3 k=2: fill then one replay
    step(0, 1, 1, 0, 3, 2);
    run_idle(100);
    idle(2);
    // redo k=3 of the same block
    step(0, 1, 0, 1, 0, 3);
    run_idle(100);
    idle(2);
    // do ni=4 k=1: fill only
    step(0, 1, 1, 0, 4, 1);
    run_idle(100);
    idle(2);
    // rejected requests
    step(0, 1, 1, 0, 0, 5);
    step(0, 1, 1, 0, 3, 0);
    step(0, 1, 0, 1, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 3);
    idle(2);
    // both requests: do wins
    step(0, 1, 1, 1, 2, 2);
    run_idle(100);
    idle(1);

    // maximum block and count, cen held low mid-replay
    step(0, 1, 1, 0, 15, 127);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    run_idle(3000);
    idle(2);

    // reset mid-replay, then a redo that must be ignored
    step(0, 1, 1, 0, 5, 3);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 2);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, c, d, rd;
      int n_in, k_in;
      r    = ($urandom_range(0, 399) == 0);
      c    = ($urandom_range(0, 9) != 0);
      d    = ($urandom_range(0, 14) == 0);
      rd   = ($urandom_range(0, 14) == 0);
      n_in = $urandom_range(0, 15);
      k_in = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      step(r, c, d, rd, n_in, k_in);
    end
    step(0, 1, 0, 0, 0, 0);
    run_idle(2000);

    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
